// File: rtl/regbank_ctrl.sv
// regbank_ctrl: four-state instruction controller (IDLE/RD/EX/WB, plus ERR)
// sequencing one ALU instruction per four cycles against an external
// register bank with combinational reads and a registered write port.
// Optional feature macro: REGCTRL_ADDR_CHECK_EN (reject addresses >= NREG).
module regbank_ctrl #(
  parameter int DW   = 9,
  parameter int NREG = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [3:0]    in_dr,
  input  logic [3:0]    in_sr1,
  input  logic [3:0]    in_sr2,
  output logic [3:0]    sr1,
  output logic [3:0]    sr2,
  input  logic [DW-1:0] dsr1,
  input  logic [DW-1:0] dsr2,
  output logic          write,
  output logic [3:0]    dr,
  output logic [DW-1:0] din,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_WB, S_ERR} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

`ifdef REGCTRL_ADDR_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  localparam logic [4:0] NREG_L = 5'(NREG);

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_op;
  logic [3:0]    r_dr;
  logic [3:0]    r_sr1;
  logic [3:0]    r_sr2;
  logic [3:0]    r_dr_out;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_result;
  logic          w_accept;
  logic          w_range_bad;
  logic          w_addr_bad;

  assign in_ready    = (r_state == S_IDLE);
  assign w_accept    = in_valid && in_ready;
  assign w_range_bad = ({1'b0, in_dr}  >= NREG_L) ||
                       ({1'b0, in_sr1} >= NREG_L) ||
                       ({1'b0, in_sr2} >= NREG_L);
  // With the check disabled the range test folds away and ERR is unreachable.
  assign w_addr_bad  = CHECK_EN & w_range_bad;

  // Read addresses and write address are held registers, so the bank sees
  // stable values between instructions.
  assign sr1 = r_sr1;
  assign sr2 = r_sr2;
  assign dr  = r_dr_out;
  assign din = r_result;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_next = r_state;
    write  = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_addr_bad ? S_ERR : S_RD;
      S_RD:   w_next = S_EX;
      S_EX:   w_next = S_WB;
      S_WB: begin
        write  = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        done   = 1'b1;
        err    = CHECK_EN;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Instruction capture on acceptance; source addresses go straight out so
  // they are valid throughout RD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= '0;
      r_dr  <= '0;
      r_sr1 <= '0;
      r_sr2 <= '0;
    end else if (w_accept) begin
      r_op  <= in_op;
      r_dr  <= in_dr;
      r_sr1 <= in_sr1;
      r_sr2 <= in_sr2;
    end
  end

  // Operand fetch at the end of RD, execute at the end of EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_dr_out <= '0;
    end else begin
      if (r_state == S_RD) begin
        r_a <= dsr1;
        r_b <= dsr2;
      end
      if (r_state == S_EX) begin
        r_dr_out <= r_dr;
        case (r_op)
          OP_ADD:  r_result <= r_a + r_b;
          OP_SUB:  r_result <= r_a - r_b;
          OP_AND:  r_result <= r_a & r_b;
          default: r_result <= r_a;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regbank_ctrl.sv
// Testbench for regbank_ctrl: behavioural register bank attached to the DUT,
// plus an independent array model of register contents.
module tb_regbank_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = '0;
  logic [3:0] in_dr = '0, in_sr1 = '0, in_sr2 = '0;
  logic [3:0] sr1, sr2, dr;
  logic [8:0] dsr1, dsr2, din;
  logic       write, done, err;

  logic [8:0] bank [16];
  int         mdl  [16];
  logic       pl_en = 1'b0;
  logic [3:0] pl_addr = '0;
  logic [8:0] pl_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regbank_ctrl #(.DW(9), .NREG(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dr(in_dr), .in_sr1(in_sr1), .in_sr2(in_sr2),
    .sr1(sr1), .sr2(sr2), .dsr1(dsr1), .dsr2(dsr2),
    .write(write), .dr(dr), .din(din), .done(done), .err(err)
  );

  // Register bank: combinational reads, writes on the clock edge.
  assign dsr1 = bank[sr1];
  assign dsr2 = bank[sr2];
  always @(posedge clk) begin
    if (pl_en) bank[pl_addr] <= pl_data;
    else if (write) bank[dr] <= din;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int a, input int v);
    pl_en = 1'b1; pl_addr = 4'(a); pl_data = 9'(v);
    tick;
    pl_en = 1'b0;
    mdl[a] = v;
  endtask

  function automatic int ref_result(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 512;
      1: return (a - b + 512) % 512;
      2: return a & b;
      default: return a;
    endcase
  endfunction

  function automatic bit addr_rejected(input int d, input int s1, input int s2);
`ifdef REGCTRL_ADDR_CHECK_EN
    return (d >= 10) || (s1 >= 10) || (s2 >= 10);
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_ready;
    int w = 0;
    while (!in_ready && w < 10) begin tick; w++; end
    chk("ready_before_offer", 32'(in_ready), 1);
  endtask

  task automatic run_instr(input int op, input int d, input int s1, input int s2, input bit pulse_rd);
    int res;
    wait_ready;
    in_valid = 1'b1; in_op = 2'(op); in_dr = 4'(d); in_sr1 = 4'(s1); in_sr2 = 4'(s2);
    tick;                                   // accept edge -> RD (or ERR)
    in_valid = 1'b0;
    chk("busy_ready", 32'(in_ready), 0);
    chk("acc1_write", 32'(write), 0);
    if (addr_rejected(d, s1, s2)) begin
      chk("err_done", 32'(done), 1);
      chk("err_err", 32'(err), 1);
      tick;
      chk("err_idle_ready", 32'(in_ready), 1);
      chk("err_idle_write", 32'(write), 0);
      chk("err_idle_done", 32'(done), 0);
      $display("instr op=%0d dr=%0d sr1=%0d sr2=%0d -> rejected", op, d, s1, s2);
      return;
    end
    chk("rd_sr1", 32'(sr1), 32'(s1));
    chk("rd_sr2", 32'(sr2), 32'(s2));
    chk("rd_done", 32'(done), 0);
    res = ref_result(op, mdl[s1], mdl[s2]);
    if (pulse_rd) begin
      in_valid = 1'b1; in_op = 2'(op + 1); in_dr = 4'(d + 1);
    end
    tick;                                   // EX
    in_valid = 1'b0;
    chk("ex_write", 32'(write), 0);
    chk("ex_done", 32'(done), 0);
    tick;                                   // WB
    chk("wb_write", 32'(write), 1);
    chk("wb_dr", 32'(dr), 32'(d));
    chk("wb_din", 32'(din), 32'(res));
    chk("wb_done", 32'(done), 1);
    chk("wb_err", 32'(err), 0);
    mdl[d] = res;
    tick;                                   // back in IDLE
    chk("post_ready", 32'(in_ready), 1);
    chk("post_write", 32'(write), 0);
    chk("hold_dr", 32'(dr), 32'(d));
    chk("hold_din", 32'(din), 32'(res));
    chk("bank_val", 32'(bank[d]), 32'(mdl[d]));
    $display("instr op=%0d dr=%0d sr1=%0d sr2=%0d -> din=%0d", op, d, s1, s2, res);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin bank[i] = '0; mdl[i] = 0; end
    #3;
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_write", 32'(write), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sr1", 32'(sr1), 0);
    chk("rst_dr", 32'(dr), 0);
    chk("rst_din", 32'(din), 0);
    tick;
    rst = 1'b0;
    tick;

    preload(3, 100);
    preload(4, 50);
    run_instr(0, 5, 3, 4, 1'b0);            // ADD -> 150
    run_instr(1, 6, 4, 3, 1'b0);            // SUB 50-100 -> 462
    run_instr(0, 7, 5, 5, 1'b0);            // back-to-back, uses fresh r5 -> 300
    chk("r7_fresh", 32'(bank[7]), 300);
    preload(8, 400);
    preload(9, 300);
    run_instr(0, 1, 8, 9, 1'b1);            // 700 mod 512 = 188, pulse in RD
    for (int i = 0; i < 4; i++) begin
      chk("no_extra_done", 32'(done), 0);
      tick;
    end
    run_instr(3, 12, 1, 0, 1'b0);           // MOV to out-of-range dr

    // Reset in EX of AND dr=2 aborts without writing.
    wait_ready;
    in_valid = 1'b1; in_op = 2'd2; in_dr = 4'd2; in_sr1 = 4'd3; in_sr2 = 4'd4;
    tick;                                   // RD
    in_valid = 1'b1; in_dr = 4'd9;          // ignored offer during RD
    tick;                                   // EX
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(in_ready), 1);
    chk("arst_write", 32'(write), 0);
    chk("arst_din", 32'(din), 0);
    chk("arst_dr", 32'(dr), 0);
    tick;
    rst = 1'b0;
    tick;
    chk("after_rst_ready", 32'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      chk("after_rst_quiet", 32'({write, done}), 0);
      tick;
    end
    chk("r2_unchanged", 32'(bank[2]), 32'(mdl[2]));
    $display("instr op=2 dr=2 sr1=3 sr2=4 -> aborted by reset");

    // Randomised instructions over valid addresses.
    for (int i = 0; i < 10; i++) preload(i, int'($urandom_range(0, 511)));
    for (int i = 0; i < 25; i++)
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regbank_ctrl.md
REGBANK_CTRL -- requirements
Module: regbank_ctrl

Interface
REQ-001 Parameter: DW, 9, data width of register file words.
REQ-002 Parameter: NREG, 10, number of valid register addresses (0..NREG-1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_ready  output  1  controller can accept an instruction.
REQ-007 in_op  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 MOV.
REQ-008 in_dr, in_sr1, in_sr2  input  4 each  destination and source register addresses.
REQ-009 sr1, sr2  output  4 each  read addresses driven to the register bank.
REQ-010 dsr1, dsr2  input  DW each  read data returned combinationally by the register bank for sr1/sr2.
REQ-011 write  output  1  register-bank write enable.
REQ-012 dr  output  4  register-bank write address.
REQ-013 din  output  DW  register-bank write data.
REQ-014 done  output  1  one-cycle pulse: instruction retired (written or rejected).
REQ-015 err  output  1  one-cycle pulse, coincident with done, when an instruction is rejected.

Function
REQ-016 FSM states: IDLE, RD, EX, WB, ERR; in_ready SHALL be 1 only in IDLE.
REQ-017 Handshake: instruction accepted on a rising edge where in_valid=1 and in_ready=1; op/dr/sr1/sr2 captured into internal registers at that edge.
REQ-018 IDLE -> RD on acceptance (valid addresses); IDLE -> ERR on acceptance with a rejected address (see Configuration); otherwise remain IDLE.
REQ-019 RD (accept+1): sr1/sr2 SHALL equal captured sources; dsr1/dsr2 sampled into operand registers A/B at the end of RD; RD -> EX unconditionally.
REQ-020 EX (accept+2): result computed from A/B: ADD = (A+B) mod 2^DW; SUB = (A-B) mod 2^DW (two's-complement wrap); AND = A&B; MOV = A; result registered at end of EX; EX -> WB.
REQ-021 WB (accept+3): write=1, dr=captured destination, din=result, done=1 for exactly that cycle; WB -> IDLE.
REQ-022 Latency: accept edge to write cycle = 3 cycles; throughput 1 instruction per 4 cycles; in_ready returns to 1 in the cycle after WB.
REQ-023 ERR: done=1, err=1, write=0 for one cycle; ERR -> IDLE; no register-bank write issued.
REQ-024 write SHALL be 0 in every state except WB; done/err 0 outside WB/ERR.
REQ-025 sr1/sr2 hold last driven values outside RD; dr/din hold last values outside WB.
REQ-026 in_valid while in_ready=0 SHALL be ignored; the pending instruction is not captured or queued.
REQ-027 Read-after-write: an instruction accepted in the cycle after WB sees the just-written value because its RD cycle follows the write edge.
REQ-028 sr1=sr2 and dr equal to a source are legal; result uses pre-write operands.

Reset
REQ-029 rst=1 forces immediately (asynchronously) state=IDLE, write=0, done=0, err=0, sr1=sr2=0, dr=0, din=0, A=B=0, result=0.
REQ-030 in_ready=1 after reset deasserts; reset asserted in RD/EX/WB aborts the instruction with no write issued.

Configuration
REQ-031 Macro REGCTRL_ADDR_CHECK_EN: when defined, any of in_dr/in_sr1/in_sr2 >= NREG at acceptance routes to ERR.
REQ-032 When REGCTRL_ADDR_CHECK_EN is undefined: no check, ERR unreachable, err tied 0, out-of-range addresses forwarded unchanged to sr1/sr2/dr.

Verification
REQ-033 Reset, preload r3=100, r4=50 via bank; ADD dr=5 sr1=3 sr2=4 -> write=1 at accept+3, dr=5, din=150, done=1, r5=150.
REQ-034 SUB dr=6 sr1=4 sr2=3 (50-100) -> din=462 (wrap mod 512); ADD r=400+300 -> din=188.
REQ-035 Back-to-back: ADD dr=7 sr1=5 sr2=5 offered in cycle after previous WB with in_valid held -> in_ready=1, accepted, r7=300 (uses fresh r5=150).
REQ-036 With REGCTRL_ADDR_CHECK_EN: MOV dr=12 sr1=1 -> ERR cycle at accept+1, done=1, err=1, write never asserted; without macro: write at accept+3 with dr=12, err=0.
REQ-037 Assert rst during EX of AND dr=2 -> write stays 0, r2 unchanged, in_ready=1 after release; in_valid pulsed during RD is ignored (no extra done).
